// File: rtl/tx_pkg.sv
// Shared definitions for the BPSK transmit framer.
// Holds the framer FSM state encoding, the two's-complement BPSK symbol
// constants and the default Barker-7 preamble word.
package tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPre   = 2'd1,
    StPay   = 2'd2,
    StGuard = 2'd3
  } tx_state_e;

  localparam logic [1:0] SymPos  = 2'b01;  // bit 1 -> +1
  localparam logic [1:0] SymNeg  = 2'b11;  // bit 0 -> -1
  localparam logic [1:0] SymIdle = 2'b00;  // no energy

  // Barker-7, MSB first: 1110010
  localparam logic [31:0] Barker7 = 32'h0000_0072;

  // Largest of three segment lengths, used to size the symbol counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sym_timer.sv
// Free-running symbol timer.
// Counts 0..DIV-1 on clk_sig and wraps; sym_tick is high while the count
// sits at DIV-1, i.e. during the last cycle of every symbol period.
// Ports:
//   clk_sig  - clock (rising edge)
//   rst_n    - asynchronous active-low reset, count returns to 0
//   sym_tick - end-of-symbol strobe
module sym_timer #(
  parameter int unsigned DIV = 5
) (
  input  logic clk_sig,
  input  logic rst_n,
  output logic sym_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign sym_tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = sym_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_framer.sv
// BPSK transmit framer: preamble, payload and optional guard, one symbol
// per DIV clocks.
// Ports:
//   clk_sig     - clock (rising edge, the only clock)
//   rst_n       - asynchronous active-low reset, aborts any frame
//   start_p     - one-cycle frame request (CONT=0 only), ignored when busy
//   data_sig    - payload bit
//   data_valid  - data_sig is valid
//   data_ready  - payload bit consumed this cycle
//   sym_sig     - BPSK symbol (+1 = 01, -1 = 11, idle = 00)
//   sym_stb     - first cycle of each symbol
//   sel_sig     - 0 during preamble, 1 otherwise
//   frame_start - first cycle of preamble symbol 0
//   busy        - FSM not idle
//   underrun    - sticky: a payload symbol lacked valid data
module tx_framer
  import tx_pkg::*;
#(
  parameter int unsigned PRE_LEN     = 7,
  parameter logic [31:0] PRE_PATTERN = Barker7,
  parameter int unsigned PAY_LEN     = 50,
  parameter int unsigned GUARD_LEN   = 0,
  parameter int unsigned DIV         = 5,
  parameter int unsigned CONT        = 1
) (
  input  logic       clk_sig,
  input  logic       rst_n,
  input  logic       start_p,
  input  logic       data_sig,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [1:0] sym_sig,
  output logic       sym_stb,
  output logic       sel_sig,
  output logic       frame_start,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned CW = $clog2(max3(PRE_LEN, PAY_LEN, GUARD_LEN)) + 1;

  logic          sym_tick;
  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic [1:0]    sym_q, sym_d;
  logic          stb_q, stb_d;
  logic          sel_q, sel_d;
  logic          fs_q, fs_d;
  logic          underrun_q, underrun_d;
  logic          ur_set;
  logic [4:0]    pre_idx;

  sym_timer #(
    .DIV (DIV)
  ) u_sym_timer (
    .clk_sig  (clk_sig),
    .rst_n    (rst_n),
    .sym_tick (sym_tick)
  );

  // The registered state/counter name the symbol currently on sym_sig. On a
  // tick the next symbol is decided from state_d/cnt_d and loaded together
  // with it, so outputs change on the cycle after sym_tick.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    sym_d      = sym_q;
    stb_d      = 1'b0;
    sel_d      = sel_q;
    fs_d       = 1'b0;
    data_ready = 1'b0;
    ur_set     = 1'b0;
    pre_idx    = '0;

    if (state_q == StIdle && start_p) begin
      start_d = 1'b1;
    end

    if (sym_tick) begin
      stb_d = 1'b1;
      unique case (state_q)
        StIdle: begin
          if (CONT != 0 || start_q || start_p) state_d = StPre;
        end
        StPre: begin
          if (cnt_q == CW'(PRE_LEN - 1)) state_d = StPay;
          else cnt_d = cnt_q + 1'b1;
        end
        StPay: begin
          if (cnt_q == CW'(PAY_LEN - 1)) begin
            if (GUARD_LEN != 0) state_d = StGuard;
            else state_d = (CONT != 0) ? StPre : StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StGuard: begin
          if (cnt_q == CW'(GUARD_LEN - 1)) state_d = (CONT != 0) ? StPre : StIdle;
          else cnt_d = cnt_q + 1'b1;
        end
        default: state_d = StIdle;
      endcase

      if (state_d != state_q) cnt_d = '0;
      // Any tick in idle either consumes the request or there was none.
      if (state_q == StIdle) start_d = 1'b0;

      unique case (state_d)
        StPre: begin
          sel_d   = 1'b0;
          pre_idx = 5'(PRE_LEN - 1 - 32'(cnt_d));
          sym_d   = PRE_PATTERN[pre_idx] ? SymPos : SymNeg;
          fs_d    = (state_q != StPre);
        end
        StPay: begin
          // Bit for the payload symbol that starts on the next cycle.
          sel_d      = 1'b1;
          data_ready = 1'b1;
          if (data_valid) begin
            sym_d = data_sig ? SymPos : SymNeg;
          end else begin
            sym_d  = SymIdle;
            ur_set = 1'b1;
          end
        end
        default: begin
          sel_d = 1'b1;
          sym_d = SymIdle;
        end
      endcase
    end

    // Clear on the edge that raises frame_start; a same-cycle set wins.
    if (ur_set) underrun_d = 1'b1;
    else if (fs_d) underrun_d = 1'b0;
    else underrun_d = underrun_q;
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      sym_q      <= SymIdle;
      stb_q      <= 1'b0;
      sel_q      <= 1'b1;
      fs_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      sym_q      <= sym_d;
      stb_q      <= stb_d;
      sel_q      <= sel_d;
      fs_q       <= fs_d;
      underrun_q <= underrun_d;
    end
  end

  assign sym_sig     = sym_q;
  assign sym_stb     = stb_q;
  assign sel_sig     = sel_q;
  assign frame_start = fs_q;
  assign busy        = (state_q != StIdle);
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer. Three instances:
//   dut0 - defaults (continuous, DIV=5, Barker-7, 50 payload symbols)
//   dut1 - CONT=0, PAY_LEN=4, GUARD_LEN=3, DIV=2
//   dut2 - Barker-13 preamble, PAY_LEN=1, DIV=2, continuous
module tb_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  logic st0, st1, st2;
  logic d0, d1, d2;
  logic dv0, dv1, dv2;
  logic dr0, dr1, dr2;
  logic [1:0] sym0, sym1, sym2;
  logic stb0, stb1, stb2;
  logic sel0, sel1, sel2;
  logic fs0, fs1, fs2;
  logic busy0, busy1, busy2;
  logic ur0, ur1, ur2;

  int n_asserts = 0;
  int n_fail = 0;
  logic [6:0]  bk7;
  logic [12:0] bk13;

  tx_framer u_dut0 (
    .clk_sig(clk), .rst_n(rst0), .start_p(st0), .data_sig(d0), .data_valid(dv0),
    .data_ready(dr0), .sym_sig(sym0), .sym_stb(stb0), .sel_sig(sel0),
    .frame_start(fs0), .busy(busy0), .underrun(ur0)
  );

  tx_framer #(
    .CONT(0), .PAY_LEN(4), .GUARD_LEN(3), .DIV(2)
  ) u_dut1 (
    .clk_sig(clk), .rst_n(rst1), .start_p(st1), .data_sig(d1), .data_valid(dv1),
    .data_ready(dr1), .sym_sig(sym1), .sym_stb(stb1), .sel_sig(sel1),
    .frame_start(fs1), .busy(busy1), .underrun(ur1)
  );

  tx_framer #(
    .PRE_LEN(13), .PRE_PATTERN(32'h0000_1F35), .PAY_LEN(1), .DIV(2), .CONT(1)
  ) u_dut2 (
    .clk_sig(clk), .rst_n(rst2), .start_p(st2), .data_sig(d2), .data_valid(dv2),
    .data_ready(dr2), .sym_sig(sym2), .sym_stb(stb2), .sel_sig(sel2),
    .frame_start(fs2), .busy(busy2), .underrun(ur2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, negedge to negedge. dut0 payload alternates: toggle d0 after
  // every posedge on which dut0 consumed a bit.
  task automatic step();
    logic dr_s;
    dr_s = dr0;
    @(posedge clk);
    #1;
    if (dr_s) d0 = ~d0;
    @(negedge clk);
  endtask

  // One full dut0 frame from the frame_start cycle. drop >= 0 withholds
  // data_valid for that payload index.
  task automatic frame0(input int drop);
    int sel_cnt;
    int k;
    logic [1:0] e;
    sel_cnt = 0;
    for (int c = 0; c < 285; c++) begin
      if (sel0 == 1'b0) sel_cnt++;
      if (c % 5 == 0) begin
        k = c / 5;
        if (k < 7) e = bk7[6-k] ? 2'b01 : 2'b11;
        else if (k - 7 == drop) e = 2'b00;
        else e = ((k - 7) % 2 == 0) ? 2'b01 : 2'b11;
        chk("sym0", 32'(sym0), 32'(e));
        chk("stb0_high", 32'(stb0), 32'd1);
      end
      if (c % 5 == 1) chk("stb0_low", 32'(stb0), 32'd0);
      if (drop >= 0 && c == (drop + 6) * 5 + 4) dv0 = 1'b0;
      if (drop >= 0 && c == (drop + 6) * 5 + 5) begin
        chk("underrun_set", 32'(ur0), 32'd1);
        dv0 = 1'b1;
      end
      if (c == 284) chk("underrun_hold", 32'(ur0), (drop >= 0) ? 32'd1 : 32'd0);
      step();
    end
    chk("frame0_period", 32'(fs0), 32'd1);
    chk("sel0_low_cycles", 32'(sel_cnt), 32'd35);
    chk("underrun_clear", 32'(ur0), 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    logic [1:0] e;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    d0 = 1'b1; d1 = 1'b1; d2 = 1'b0;
    dv0 = 1'b1; dv1 = 1'b1; dv2 = 1'b1;
    bk7 = 7'b1110010;
    bk13 = 13'b1111100110101;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_sym", 32'(sym0), 32'd0);
    chk("rst_stb", 32'(stb0), 32'd0);
    chk("rst_sel", 32'(sel0), 32'd1);
    chk("rst_fs", 32'(fs0), 32'd0);
    chk("rst_dr", 32'(dr0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ur", 32'(ur0), 32'd0);

    // Continuous default framing
    rst0 = 1'b1;
    n = 0;
    while (!fs0 && n < 20) begin step(); n++; end
    chk("fs0_latency", 32'(n), 32'd5);
    chk("busy0", 32'(busy0), 32'd1);
    frame0(-1);
    frame0(10);

    // Reset in the middle of payload symbol 20
    repeat (137) step();
    chk("pay20_sel", 32'(sel0), 32'd1);
    chk("pay20_busy", 32'(busy0), 32'd1);
    rst0 = 1'b0;
    #1;
    chk("arst_sym", 32'(sym0), 32'd0);
    chk("arst_sel", 32'(sel0), 32'd1);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_stb", 32'(stb0), 32'd0);
    chk("arst_dr", 32'(dr0), 32'd0);
    step();
    step();
    rst0 = 1'b1;
    n = 0;
    while (!fs0 && n < 20) begin step(); n++; end
    chk("fs0_after_reset", 32'(n), 32'd5);
    chk("restart_sym", 32'(sym0), 32'd1);
    chk("restart_sel", 32'(sel0), 32'd0);

    // Single-shot framing with guard
    rst1 = 1'b1;
    repeat (10) step();
    chk("idle1_busy", 32'(busy1), 32'd0);
    chk("idle1_sym", 32'(sym1), 32'd0);
    st1 = 1'b1;
    step();
    st1 = 1'b0;
    n = 0;
    while (!fs1 && n < 10) begin step(); n++; end
    chk("fs1_seen", 32'(fs1), 32'd1);
    cnt = 0;
    for (int c = 0; c < 28; c++) begin
      if (dr1) cnt++;
      if (c == 4) st1 = 1'b1;
      if (c == 5) st1 = 1'b0;
      if (c == 20) chk("last_pay1", 32'(sym1), 32'd1);
      if (c == 22 || c == 24 || c == 26) begin
        chk("guard1_sym", 32'(sym1), 32'd0);
        chk("guard1_sel", 32'(sel1), 32'd1);
      end
      if (c == 27) chk("guard1_busy", 32'(busy1), 32'd1);
      step();
    end
    chk("done1_busy", 32'(busy1), 32'd0);
    chk("dr1_count", 32'(cnt), 32'd4);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (fs1) cnt++;
    end
    chk("no_second_frame", 32'(cnt), 32'd0);
    chk("idle1_busy_end", 32'(busy1), 32'd0);

    // Barker-13 preamble, single payload symbol
    rst2 = 1'b1;
    n = 0;
    while (!fs2 && n < 10) begin step(); n++; end
    chk("fs2_seen", 32'(fs2), 32'd1);
    cnt = 0;
    for (int c = 0; c < 28; c++) begin
      if (dr2) cnt++;
      if (c % 2 == 0) begin
        if (c / 2 < 13) e = bk13[12 - c / 2] ? 2'b01 : 2'b11;
        else e = 2'b11;
        chk("sym2", 32'(sym2), 32'(e));
      end
      step();
    end
    chk("frame2_period", 32'(fs2), 32'd1);
    chk("dr2_count", 32'(cnt), 32'd1);
    step();
    chk("fs2_pulse_width", 32'(fs2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 Parameter PRE_LEN, default 7: preamble length in symbols (2..32).
REQ-002 Parameter PRE_PATTERN, default 32'h0000_0072: preamble bits; bit PRE_LEN-1 is sent first (default 1110010, the Barker-7 word).
REQ-003 Parameter PAY_LEN, default 50: payload length in symbols (1..4095).
REQ-004 Parameter GUARD_LEN, default 0: idle symbols after the payload (0..255).
REQ-005 Parameter DIV, default 5: clk_sig cycles per symbol (2..1023).
REQ-006 Parameter CONT, default 1: 1 = frames repeat back-to-back; 0 = each frame waits for start_p.
REQ-007 clk_sig  input  1  the only clock; all logic is rising-edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start_p  input  1  single-cycle request to start a frame; used only when CONT=0.
REQ-010 data_sig  input  1  payload bit (coded stream).
REQ-011 data_valid  input  1  data_sig is valid.
REQ-012 data_ready  output  1  one-cycle pulse; data_sig is consumed on this cycle when data_valid=1.
REQ-013 sym_sig  output  2  BPSK symbol, two's complement: bit 1 -> 2'b01 (+1), bit 0 -> 2'b11 (-1), idle -> 2'b00.
REQ-014 sym_stb  output  1  one-cycle pulse marking the first cycle of each new symbol.
REQ-015 sel_sig  output  1  0 during preamble, 1 otherwise; drives the downstream mux select.
REQ-016 frame_start  output  1  one-cycle pulse coincident with sym_stb of preamble symbol 0.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 underrun  output  1  sticky flag; a payload symbol was needed while data_valid=0.

Function
REQ-019 Symbol timer counts 0..DIV-1 and wraps; sym_tick is asserted when the count is DIV-1. The timer free-runs in all states, including IDLE.
REQ-020 FSM states: IDLE, PRE, PAY, GUARD. Every state transition occurs only on sym_tick.
REQ-021 IDLE -> PRE on sym_tick if CONT=1, or if a start request is latched; start_p arriving between ticks is held until the next tick.
REQ-022 PRE -> PAY after PRE_LEN symbols.
REQ-023 PAY -> GUARD after PAY_LEN symbols; if GUARD_LEN=0, PAY goes directly to PRE (CONT=1) or IDLE (CONT=0).
REQ-024 GUARD -> PRE (CONT=1) or IDLE (CONT=0) after GUARD_LEN symbols.
REQ-025 A per-state symbol counter, $clog2(max length)+1 bits wide, clears on every state entry.
REQ-026 sym_sig, sym_stb, sel_sig and frame_start are registered and update on the cycle after sym_tick; each symbol is held for exactly DIV cycles.
REQ-027 In PAY, data_ready pulses on sym_tick. If data_valid=1, the symbol carries data_sig. If data_valid=0, the symbol is idle (2'b00) and underrun is set; the payload counter still advances, so frame length is fixed.
REQ-028 underrun clears on frame_start, unless an underrun occurs in that same cycle; the set wins.
REQ-029 data_ready is never asserted outside PAY.
REQ-030 start_p received while busy is ignored; it is not queued.
REQ-031 In IDLE and GUARD, sym_sig=2'b00 and sel_sig=1.

Reset
REQ-032 While rst_n=0: state=IDLE, all counters=0, sym_sig=2'b00, sym_stb=0, sel_sig=1, frame_start=0, data_ready=0, busy=0, underrun=0, latched start cleared.
REQ-033 Reset asserted mid-frame aborts the frame immediately. After release, a fresh frame starts from preamble symbol 0; no partial frame resumes.

Structure
REQ-034 Shared package tx_pkg holds the FSM state encoding, the BPSK symbol constants (+1, -1, idle) and the default Barker-7 pattern.
REQ-035 The symbol timer is a separate sub-module, sym_timer, parameterised by DIV and providing a sym_tick output.
REQ-036 All other logic lives in tx_framer; no gated or derived clocks are used.

Verification
REQ-037 Default parameters, data_valid tied 1, data alternating 1/0: sym_sig sequence +1 +1 +1 -1 -1 +1 -1, then 50 alternating symbols, repeating; frame_start pulses every 57×5 = 285 cycles; sel_sig=0 for exactly 35 cycles per frame.
REQ-038 CONT=0, pulse start_p once: exactly one frame, then IDLE with busy=0. A second start_p issued mid-frame has no effect.
REQ-039 data_valid=0 for payload symbol 10 only: that symbol is 2'b00, underrun=1 until the next frame_start, and the frame is still 57 symbols long.
REQ-040 GUARD_LEN=3, DIV=2: three idle symbols (6 cycles) between the last payload symbol and the next frame_start.
REQ-041 rst_n pulsed low during payload symbol 20: outputs reach reset values asynchronously; the first frame_start after release follows the first sym_tick.
REQ-042 PRE_LEN=13 with the Barker-13 pattern (1111100110101), PAY_LEN=1: frame is 14 symbols, and data_ready pulses exactly once per frame.
